accumulate_ctrl: RTL and testbench

- Sits directly upstream of the adder datapath in the lab-3 adder top level.
- Conditions the raw active-low Run_Accumulate push-button: synchronises it, debounces it, and turns each press into exactly one accumulate operation.
- Owns the accumulator register A and the latched switch operand B that drive the adder; captures the adder's Sum/Cout back into A.
- The adder is combinational and sits between this block's A/B outputs and its Sum/Cout inputs.

---
 rtl/lab3_pkg.sv | 16 +
 rtl/sync2.sv | 30 +++
 rtl/accumulate_ctrl.sv | 142 ++++++++++++++
 tb/tb_accumulate_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_pkg.sv
// Shared types and constants for the lab-3 adder front end.
//   acc_state_t : accumulate controller FSM state encoding
//   SW_WIDTH    : number of operand switches on the board
package lab3_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    CAPTURE,
    LOAD,
    RELEASE
  } acc_state_t;

  localparam int SW_WIDTH = 10;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a single asynchronous input.
//   i_clk : destination clock
//   i_rst : asynchronous active-high reset, forces both flops to RESET_VAL
//   i_d   : asynchronous input
//   o_q   : synchronised output, two clocks behind i_d
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/accumulate_ctrl.sv
// Push-button accumulate controller sitting in front of the combinational adder.
// Synchronises and debounces the active-low Run_Accumulate button and turns each
// debounced press into exactly one A <= A + B operation.
//
// state    | meaning
// IDLE     | waiting for the button to be pressed
// DEBOUNCE | button seen pressed, waiting for it to stay pressed
// CAPTURE  | latch the switch operand into B
// LOAD     | write adder Sum into A, fold Cout into Overflow
// RELEASE  | waiting for a debounced release before re-arming
//
// Ports:
//   Clk            : system clock
//   Reset          : asynchronous active-high reset
//   Run_Accumulate : raw push-button, 0 = pressed, asynchronous to Clk
//   SW             : operand switches
//   Sum, Cout      : adder result for A + B
//   A              : accumulator register
//   B              : latched operand, zero-extended SW
//   Load           : high for the single cycle in which A is written
//   Busy           : high whenever the FSM is not in IDLE
//   Overflow       : sticky adder carry-out
module accumulate_ctrl
  import lab3_pkg::*;
#(
  parameter int WIDTH           = 17,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run_Accumulate,
  input  logic [SW_WIDTH-1:0] SW,
  input  logic [WIDTH-1:0]    Sum,
  input  logic                Cout,
  output logic [WIDTH-1:0]    A,
  output logic [WIDTH-1:0]    B,
  output logic                Load,
  output logic                Busy,
  output logic                Overflow
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  acc_state_t       r_state;
  acc_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_ovf;
  logic             w_sync;
  logic             w_btn_p;

  // Synchroniser resets to "released" so a held button after Reset is seen
  // as a fresh press edge from IDLE.
  sync2 #(.RESET_VAL(1'b1)) u_sync_btn (
    .i_clk (Clk),
    .i_rst (Reset),
    .i_d   (Run_Accumulate),
    .o_q   (w_sync)
  );

  assign w_btn_p = ~w_sync;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Counter is forced to zero on every transition so each state starts its
  // stability window fresh.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (w_btn_p) w_state_next = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!w_btn_p) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_TC) begin
          w_state_next = CAPTURE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      CAPTURE: begin
        w_state_next = LOAD;
        w_cnt_next   = '0;
      end
      LOAD: begin
        w_state_next = RELEASE;
        w_cnt_next   = '0;
      end
      RELEASE: begin
        if (w_btn_p) begin
          w_cnt_next = '0;
        end else if (r_cnt == CNT_TC) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (r_state == CAPTURE) r_b <= WIDTH'(SW);
      if (r_state == LOAD) begin
        r_a   <= Sum;
        r_ovf <= r_ovf | Cout;
      end
    end
  end

  assign A        = r_a;
  assign B        = r_b;
  assign Overflow = r_ovf;
  assign Load     = (r_state == LOAD);
  assign Busy     = (r_state != IDLE);

endmodule

// File: tb/tb_accumulate_ctrl.sv
// Bench for accumulate_ctrl: a default-width (17) and a 10-bit instance share
// the button/switch stimulus, each closed through its own behavioural adder.
module tb_accumulate_ctrl;

  localparam int DC  = 4;
  localparam int GAP = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pin = 1'b1;
  logic [9:0]  SW  = '0;

  logic [16:0] a17, b17, sum17;
  logic        cout17, load17, busy17, ovf17;
  logic [9:0]  a10, b10, sum10;
  logic        cout10, load10, busy10, ovf10;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign {cout17, sum17} = {1'b0, a17} + {1'b0, b17};
  assign {cout10, sum10} = {1'b0, a10} + {1'b0, b10};

  accumulate_ctrl #(.WIDTH(17), .DEBOUNCE_CYCLES(DC)) u_dut17 (
    .Clk(clk), .Reset(rst), .Run_Accumulate(pin), .SW(SW),
    .Sum(sum17), .Cout(cout17), .A(a17), .B(b17),
    .Load(load17), .Busy(busy17), .Overflow(ovf17)
  );

  accumulate_ctrl #(.WIDTH(10), .DEBOUNCE_CYCLES(DC)) u_dut10 (
    .Clk(clk), .Reset(rst), .Run_Accumulate(pin), .SW(SW),
    .Sum(sum10), .Cout(cout10), .A(a10), .B(b10),
    .Load(load10), .Busy(busy10), .Overflow(ovf10)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    pin = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One press of `hold` low cycles followed by GAP released cycles. Optional
  // 2-cycle bounce mid-hold, 1-cycle bounce early in release, and a switch
  // change once the operand should already be latched.
  task automatic press(input logic [9:0] sw, input int hold, input bit bounce,
                       input bit rel_bounce, output int loads17, output int loads10,
                       output int lat);
    loads17 = 0;
    loads10 = 0;
    lat     = -1;
    @(negedge clk);
    SW = sw;
    for (int k = 0; k < hold + GAP; k++) begin
      if (k < hold) pin = (bounce && hold >= 14 && (k == 10 || k == 11)) ? 1'b1 : 1'b0;
      else          pin = (rel_bounce && k == hold + 3) ? 1'b0 : 1'b1;
      if (k == 12 && hold >= 13) SW = ~sw;
      @(negedge clk);
      if (load17) begin
        loads17++;
        if (lat < 0) lat = k + 1;
      end
      if (load10) loads10++;
    end
    pin = 1'b1;
  endtask

  typedef struct {
    bit          rst_before;
    logic [9:0]  sw;
    int          hold;
    bit          bounce;
    bit          rel_bounce;
    logic [16:0] exp_a17;
    logic [9:0]  exp_a10;
    bit          exp_ovf10;
    int          exp_loads;
  } vec_t;

  vec_t tbl [9];

  // Reference model state for the random phase.
  int unsigned m_a17, m_a10, m_b;
  bit          m_ovf17, m_ovf10;

  function automatic void model_reset();
    m_a17 = 0; m_a10 = 0; m_b = 0; m_ovf17 = 0; m_ovf10 = 0;
  endfunction

  function automatic void model_accumulate(input int unsigned sw);
    int unsigned s17, s10;
    s17 = m_a17 + sw;
    s10 = m_a10 + sw;
    if (s17 >= (1 << 17)) m_ovf17 = 1'b1;
    if (s10 >= (1 << 10)) m_ovf10 = 1'b1;
    m_a17 = s17 % (1 << 17);
    m_a10 = s10 % (1 << 10);
    m_b   = sw;
  endfunction

  initial begin
    int l17, l10, lat;
    logic [16:0] exp_b;
    logic [9:0]  rsw;
    int          rhold;
    bit          acc;

    tbl[0] = '{1'b1, 10'h0A9, 20, 1'b0, 1'b0, 17'h0A9, 10'h0A9, 1'b0, 1};
    tbl[1] = '{1'b0, 10'h0C5, 20, 1'b0, 1'b1, 17'h16E, 10'h16E, 1'b0, 1};
    tbl[2] = '{1'b0, 10'h3FF,  2, 1'b0, 1'b0, 17'h16E, 10'h16E, 1'b0, 0};
    tbl[3] = '{1'b0, 10'h3FF,  4, 1'b0, 1'b0, 17'h16E, 10'h16E, 1'b0, 0};
    tbl[4] = '{1'b0, 10'h001,  5, 1'b0, 1'b1, 17'h16F, 10'h16F, 1'b0, 1};
    tbl[5] = '{1'b0, 10'h155, 16, 1'b1, 1'b0, 17'h2C4, 10'h2C4, 1'b0, 1};
    tbl[6] = '{1'b1, 10'h3FF, 20, 1'b0, 1'b0, 17'h3FF, 10'h3FF, 1'b0, 1};
    tbl[7] = '{1'b0, 10'h3FF, 20, 1'b0, 1'b1, 17'h7FE, 10'h3FE, 1'b1, 1};
    tbl[8] = '{1'b0, 10'h001, 20, 1'b1, 1'b0, 17'h7FF, 10'h3FF, 1'b1, 1};

    // Power-on reset state
    repeat (2) @(negedge clk);
    chk("rst_a17",    32'(a17),    32'h0);
    chk("rst_b17",    32'(b17),    32'h0);
    chk("rst_ovf10",  32'(ovf10),  32'h0);
    chk("rst_busy17", 32'(busy17), 32'h0);
    chk("rst_load17", 32'(load17), 32'h0);
    rst = 1'b0;

    // Directed table
    exp_b = '0;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst_before) begin
        apply_reset();
        exp_b = '0;
      end
      press(tbl[i].sw, tbl[i].hold, tbl[i].bounce, tbl[i].rel_bounce, l17, l10, lat);
      if (tbl[i].exp_loads == 1) exp_b = 17'(tbl[i].sw);
      chk($sformatf("t%0d_loads17", i), 32'(l17), 32'(tbl[i].exp_loads));
      chk($sformatf("t%0d_loads10", i), 32'(l10), 32'(tbl[i].exp_loads));
      if (tbl[i].exp_loads == 1) chk($sformatf("t%0d_latency", i), 32'(lat), 32'd8);
      chk($sformatf("t%0d_a17", i),   32'(a17),   32'(tbl[i].exp_a17));
      chk($sformatf("t%0d_a10", i),   32'(a10),   32'(tbl[i].exp_a10));
      chk($sformatf("t%0d_b17", i),   32'(b17),   32'(exp_b));
      chk($sformatf("t%0d_ovf10", i), 32'(ovf10), 32'(tbl[i].exp_ovf10));
      chk($sformatf("t%0d_ovf17", i), 32'(ovf17), 32'h0);
      chk($sformatf("t%0d_busy", i),  32'(busy17), 32'h0);
    end

    // Reset takes effect with no clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_a17",   32'(a17),   32'h0);
    chk("async_a10",   32'(a10),   32'h0);
    chk("async_b17",   32'(b17),   32'h0);
    chk("async_ovf10", 32'(ovf10), 32'h0);
    chk("async_load",  32'(load17), 32'h0);
    chk("async_busy",  32'(busy10), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset during CAPTURE with the button still held
    apply_reset();
    @(negedge clk);
    SW  = 10'h123;
    pin = 1'b0;
    repeat (7) @(negedge clk);
    chk("midop_busy_pre", 32'(busy17), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("midop_a17",  32'(a17),    32'h0);
    chk("midop_b17",  32'(b17),    32'h0);
    chk("midop_busy", 32'(busy17), 32'h0);
    chk("midop_load", 32'(load17), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    l17 = 0;
    for (int k = 0; k < 30 + GAP; k++) begin
      pin = (k < 30) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (load17) l17++;
    end
    chk("midop_loads", 32'(l17), 32'd1);
    chk("midop_a17_after", 32'(a17), 32'h123);
    chk("midop_a10_after", 32'(a10), 32'h123);

    // Random presses against the reference model
    apply_reset();
    model_reset();
    for (int n = 0; n < 30; n++) begin
      rsw   = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 1023))
                                          : 10'($urandom_range(768, 1023));
      rhold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DC) : $urandom_range(DC + 1, 30);
      press(rsw, rhold, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), l17, l10, lat);
      acc = (rhold >= DC + 1);
      if (acc) model_accumulate(rsw);
      chk($sformatf("r%0d_loads17", n), 32'(l17), acc ? 32'd1 : 32'd0);
      chk($sformatf("r%0d_loads10", n), 32'(l10), acc ? 32'd1 : 32'd0);
      if (acc) chk($sformatf("r%0d_latency", n), 32'(lat), 32'd8);
      chk($sformatf("r%0d_a17", n),   32'(a17),   m_a17);
      chk($sformatf("r%0d_a10", n),   32'(a10),   m_a10);
      chk($sformatf("r%0d_b17", n),   32'(b17),   m_b);
      chk($sformatf("r%0d_b10", n),   32'(b10),   m_b);
      chk($sformatf("r%0d_ovf17", n), 32'(ovf17), 32'(m_ovf17));
      chk($sformatf("r%0d_ovf10", n), 32'(ovf10), 32'(m_ovf10));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
